// File: rtl/cdc_hs_pkg.sv
// Shared types for the four-phase req/ack clock-domain handshake (tx and rx sides).
// Ports: none. Provides the handshake FSM state encoding and the minimum synchroniser depth.
// Latency/backpressure: not applicable (types and constants only).
`timescale 1ns/1ps
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_e;

  // Fewer than two flops gives no meaningful metastability protection.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_sync_nff.sv
// N-flop single-bit synchroniser into the clk domain; async reset clears the whole chain to 0.
// Ports: clk, reset_n (async, active-low), i_async (unsynchronised bit), o_sync (synchronised bit).
// Latency: STAGES clk edges from i_async to o_sync; no backpressure.
`timescale 1ns/1ps
module cdc_sync_nff
  import cdc_hs_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  // Depths below the minimum are raised to it rather than silently building an unsafe chain.
  localparam int LP_STAGES = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [LP_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[LP_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[LP_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a four-phase req/ack handshake carrying one DATA_W word to another clock.
// Ports: clk/reset_n; s_valid/s_ready/s_data upstream; xfer_req/xfer_data/xfer_ack_async to the
//   destination; busy, done pulse; err_clr/timeout_err (active only with macro CDC_HS_TIMEOUT_EN).
// Latency: req one edge after capture, round trip about 2*SYNC_STAGES+3 clks; s_ready low until the
//   previous handshake has fully returned to zero (no buffering).
`timescale 1ns/1ps
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack_async,
  output logic              busy,
  output logic              done,
  input  logic              err_clr,
  output logic              timeout_err
);

  hs_state_e         r_state;
  hs_state_e         w_state_nxt;
  logic              r_xfer_req;
  logic              w_req_nxt;
  logic [DATA_W-1:0] r_xfer_data;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_capture;
  logic              w_s_ready;
  logic              w_ack_s;
  logic              w_to_fire;   // timeout event this cycle
  logic              w_aborted;   // current transfer ended by timeout, so no done pulse

  cdc_sync_nff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (xfer_ack_async),
    .o_sync  (w_ack_s)
  );

  // ---------------------------------------------------------------------------
  // Optional ack-wait timeout
  // ---------------------------------------------------------------------------
`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
  logic             r_aborted;
  logic             w_cnt_hit;

  assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // REQ times out waiting for ack to rise; RELEASE times out waiting for it to fall.
  always_comb begin
    w_to_fire = 1'b0;
    if (w_cnt_hit) begin
      if (r_state == HS_REQ)     w_to_fire = !w_ack_s;
      if (r_state == HS_RELEASE) w_to_fire = w_ack_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      // Restart on any state change, while idle, and after a RELEASE timeout so it re-arms.
      if ((w_state_nxt != r_state) || (r_state == HS_IDLE) || w_to_fire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A new timeout takes priority over a simultaneous clear.
      if (w_to_fire) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end

      if (w_capture) begin
        r_aborted <= 1'b0;
      end else if (w_to_fire && (r_state == HS_REQ)) begin
        r_aborted <= 1'b1;
      end
    end
  end

  assign w_aborted   = r_aborted;
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
  assign w_to_fire    = 1'b0;
  assign w_aborted    = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_xfer_req;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_s_ready   = 1'b0;
    case (r_state)
      HS_IDLE: begin
        // A stale ack still high means the previous cycle has not returned to zero.
        w_s_ready = !w_ack_s;
        if (s_valid && w_s_ready) begin
          w_capture   = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = HS_REQ;
        end
      end
      HS_REQ: begin
        if (w_ack_s || w_to_fire) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = HS_RELEASE;
        end
      end
      HS_RELEASE: begin
        w_req_nxt = 1'b0;
        if (!w_ack_s) begin
          w_done_nxt  = !w_aborted;
          w_state_nxt = HS_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = HS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HS_IDLE;
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_xfer_req <= w_req_nxt;
      r_done     <= w_done_nxt;
      if (w_capture) begin
        r_xfer_data <= s_data;
      end
    end
  end

  assign s_ready   = w_s_ready;
  assign xfer_req  = r_xfer_req;
  assign xfer_data = r_xfer_data;
  assign busy      = (r_state != HS_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          dclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_async;
  logic          busy;
  logic          done;
  logic          err_clr = 1'b0;
  logic          timeout_err;

  logic ack_drv = 1'b0;
  logic resp_en = 1'b0;
  logic resp_ack;
  assign xfer_ack_async = resp_en ? resp_ack : ack_drv;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  realtime dst_half = 15.0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] recv_q[$];

  cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .busy           (busy),
    .done           (done),
    .err_clr        (err_clr),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;
  always #(dst_half) dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse / edge counters and the "data stable while req" rule, sampled mid-cycle.
  logic          mon_req = 1'b0;
  logic [DW-1:0] mon_data = '0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (xfer_req === 1'b1 && mon_req !== 1'b1) rise_cnt++;
    if (reset_n && mon_req && xfer_req) chk("data_stable_while_req", xfer_data, mon_data);
    mon_req  = xfer_req;
    mon_data = xfer_data;
  end

  // Destination-side responder: sync req, take the word, ack after a random delay,
  // then drop ack after another random delay once req is seen low.
  logic rq1, rq2, got;
  int   rwait;
  always @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      rq1 <= 1'b0; rq2 <= 1'b0; got <= 1'b0; rwait <= 0; resp_ack <= 1'b0;
    end else begin
      rq1 <= xfer_req;
      rq2 <= rq1;
      if (!resp_en) begin
        resp_ack <= 1'b0; got <= 1'b0; rwait <= 0;
      end else if (rq2 && !resp_ack) begin
        if (!got) begin
          recv_q.push_back(xfer_data);
          got   <= 1'b1;
          rwait <= $urandom_range(0, 3);
        end else if (rwait != 0) begin
          rwait <= rwait - 1;
        end else begin
          resp_ack <= 1'b1;
          got      <= 1'b0;
          rwait    <= $urandom_range(0, 3);
        end
      end else if (!rq2 && resp_ack) begin
        if (rwait != 0) rwait <= rwait - 1;
        else            resp_ack <= 1'b0;
      end
    end
  end

  task automatic wait_req(input logic v, input int budget, output int n);
    n = 0;
    while (xfer_req !== v && n < budget) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int budget);
    int i;
    s_valid = 1'b1;
    s_data  = d;
    i = 0;
    while (s_ready !== 1'b1 && i < budget) begin
      @(negedge clk); i++;
    end
    chk("send_accepted", (i < budget), 1);
    if (i < budget) begin
      @(posedge clk);
      exp_q.push_back(d);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r0;
    int nwords;

    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ready", s_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- 1: single word A5, ack after 3 clks
    d0 = done_cnt;
    s_valid = 1'b1; s_data = 8'hA5;
    chk("t1_ready_at_capture", s_ready, 1);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0; s_data = 8'h5A;
    chk("t1_req", xfer_req, 1);
    chk("t1_data", xfer_data, 8'hA5);
    chk("t1_busy", busy, 1);
    chk("t1_ready_in_req", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("t1_data_wait", xfer_data, 8'hA5);
    ack_drv = 1'b1;
    wait_req(1'b0, 20, n);
    chk("t1_req_fall_latency", n, SS + 1);
    chk("t1_data_release", xfer_data, 8'hA5);
    ack_drv = 1'b0;
    wait_done(20, n);
    chk("t1_done_latency", n, SS + 1);
    chk("t1_idle_at_done", busy, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_data_hold_idle", xfer_data, 8'hA5);

    // ---- 2: back-to-back 11 then 22
    d0 = done_cnt; r0 = rise_cnt;
    s_valid = 1'b1; s_data = 8'h11;
    chk("t2_ready_first", s_ready, 1);
    @(posedge clk); @(negedge clk);
    s_data = 8'h22;
    chk("t2_req_first", xfer_req, 1);
    chk("t2_data_first", xfer_data, 8'h11);
    repeat (2) @(negedge clk);
    chk("t2_second_ignored", xfer_data, 8'h11);
    chk("t2_ready_blocked", s_ready, 0);
    ack_drv = 1'b1;
    wait_req(1'b0, 20, n);
    chk("t2_req_fall_first", n, SS + 1);
    ack_drv = 1'b0;
    wait_done(20, n);
    chk("t2_done_first", n, SS + 1);
    chk("t2_ready_after_done", s_ready, 1);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    chk("t2_req_second", xfer_req, 1);
    chk("t2_data_second", xfer_data, 8'h22);
    ack_drv = 1'b1;
    wait_req(1'b0, 20, n);
    chk("t2_req_fall_second", n, SS + 1);
    ack_drv = 1'b0;
    wait_done(20, n);
    chk("t2_done_second", n, SS + 1);
    repeat (3) @(negedge clk);
    chk("t2_req_rises", rise_cnt - r0, 2);
    chk("t2_done_count", done_cnt - d0, 2);

    // ---- 3: ack stuck high across reset release
    reset_n = 1'b0; ack_drv = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (SS + 1) @(negedge clk);
    chk("t3_ready_stale_ack", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_no_req", xfer_req, 0);
    end
    chk("t3_ready_still_low", s_ready, 0);
    s_valid = 1'b0;
    ack_drv = 1'b0;
    repeat (SS - 1) @(negedge clk);
    chk("t3_ready_before_sync", s_ready, 0);
    @(negedge clk);
    chk("t3_ready_after_sync", s_ready, 1);

    // ---- 4: reset while in REQ
    s_valid = 1'b1; s_data = 8'hC3;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    chk("t4_req_before", xfer_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_req_async_clear", xfer_req, 0);
    chk("t4_busy_async_clear", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t4_ready_after", s_ready, 1);
    chk("t4_busy_after", busy, 0);
    chk("t4_req_after", xfer_req, 0);
    chk("t4_data_after", xfer_data, 0);

    // ---- 5: timeout
`ifdef CDC_HS_TIMEOUT_EN
    d0 = done_cnt;
    s_valid = 1'b1; s_data = 8'h5E;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    chk("t5_req", xfer_req, 1);
    wait_req(1'b0, 40, n);
    chk("t5_req_fall_after", n, TO);
    chk("t5_timeout_err", timeout_err, 1);
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle", busy, 0);
    chk("t5_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_err_cleared", timeout_err, 0);
`else
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_timeout_err_tied", timeout_err, 0);
`endif

    // ---- 6: random traffic at two destination clock ratios
    for (int r = 0; r < 2; r++) begin
      dst_half = (r == 0) ? 15.0 : (10.0 * 2.0 / 7.0) / 2.0;
      exp_q.delete();
      recv_q.delete();
      resp_en = 1'b1;
      @(negedge clk);
      nwords = 500;
      for (int w = 0; w < nwords; w++) begin
        send(DW'($urandom), 400);
      end
      n = 0;
      while ((busy !== 1'b0 || xfer_ack_async !== 1'b0) && n < 400) begin
        @(negedge clk); n++;
      end
      chk("t6_drain", (n < 400), 1);
      repeat (10) @(negedge clk);
      chk("t6_count", recv_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
        chk("t6_word", recv_q[i], exp_q[i]);
      end
      resp_en = 1'b0;
      repeat (4) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
